// File: rtl/agc_monitor_ctrl_if.sv
// agc_monitor_ctrl_if: host command handshake and status of the AGC monitor sequencer.
interface agc_monitor_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [15:0] cmd_arg;
    logic        halted;
    logic        done;
    logic        err;
    logic [15:0] steps_left;
    modport master (output cmd_valid, cmd_op, cmd_arg, input cmd_ready, halted, done, err, steps_left);
    modport slave  (input cmd_valid, cmd_op, cmd_arg, output cmd_ready, halted, done, err, steps_left);
endinterface

// File: rtl/agc_monitor_ctrl.sv
// agc_monitor_ctrl: command-driven sequencer for the AGC monitor-control inputs
// (halt, run, step, restart), with completion taken from MT12 and MGOJAM.
module agc_monitor_ctrl #(
    parameter int STRT_PULSE_CYC    = 64,
    parameter int RESTART_PULSE_CYC = 256,
    parameter int TIMEOUT_CYC       = 65535
) (
    input  logic              SYS_CLK,
    input  logic              SYS_RST,
    agc_monitor_ctrl_if.slave cmd,
    input  logic              MT12,
    input  logic              MGOJAM,
    output logic              MSTP,
    output logic              MSTRTP,
    output logic              STRT2,
    output logic              MNHRPT,
    output logic              OVNHRP
);
    typedef enum logic [2:0] {
        IDLE_RUN, IDLE_HALT, HALTING, STEP_PULSE, STEP_WAIT, RST_PULSE, RST_JAM, RST_CLR
    } state_t;

    localparam logic [2:0]  OP_NOP = 3'd0, OP_HALT = 3'd1, OP_RUN = 3'd2, OP_STEP = 3'd3;
    localparam logic [2:0]  OP_RESTART = 3'd4, OP_SETCFG = 3'd5;
    localparam logic [15:0] SP_LAST  = 16'(STRT_PULSE_CYC - 1);
    localparam logic [15:0] RP_LAST  = 16'(RESTART_PULSE_CYC - 1);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYC - 1);

    state_t      r_state, w_state, w_idle;
    logic        r_mt12, r_mstp, w_mstp, r_mstrtp, w_mstrtp, r_strt2, w_strt2;
    logic        r_mnhrpt, w_mnhrpt, r_ovnhrp, w_ovnhrp, r_halted, w_halted;
    logic        r_done, w_done, r_err, w_err, r_ready, r_seen, w_seen;
    logic        w_rise, w_accept, w_wait;
    logic [15:0] r_steps, w_steps, w_steps_dec, r_pcnt, w_pcnt, r_tmo, w_tmo;

    assign w_rise      = MT12 & ~r_mt12;
    assign w_accept    = cmd.cmd_valid & r_ready;
    assign w_idle      = r_mstp ? IDLE_HALT : IDLE_RUN;
    assign w_steps_dec = r_steps - 16'd1;

    always_comb begin
        w_state  = r_state;
        w_mstp   = r_mstp;
        w_mstrtp = r_mstrtp;
        w_strt2  = r_strt2;
        w_mnhrpt = r_mnhrpt;
        w_ovnhrp = r_ovnhrp;
        w_halted = r_halted;
        w_done   = 1'b0;
        w_err    = r_err;
        w_steps  = r_steps;
        w_pcnt   = r_pcnt + 16'd1;
        w_tmo    = r_tmo + 16'd1;
        w_seen   = r_seen;
        w_wait   = 1'b0;
        if (w_accept) begin
            w_err  = 1'b0;
            w_done = 1'b1;
            w_pcnt = '0;
            w_tmo  = '0;
            w_seen = 1'b0;
            case (cmd.cmd_op)
                OP_NOP: ;
                OP_HALT: if (r_state == IDLE_RUN) begin
                    w_mstp  = 1'b1;
                    w_done  = 1'b0;
                    w_state = HALTING;
                end
                OP_RUN: begin
                    w_mstp   = 1'b0;
                    w_halted = 1'b0;
                    w_state  = IDLE_RUN;
                end
                OP_STEP: if (r_state == IDLE_RUN) w_err = 1'b1;
                    else if (cmd.cmd_arg != 16'd0) begin
                        w_done   = 1'b0;
                        w_steps  = cmd.cmd_arg;
                        w_mstrtp = 1'b1;
                        w_state  = STEP_PULSE;
                    end
                OP_RESTART: begin
                    w_done  = 1'b0;
                    w_strt2 = 1'b1;
                    w_state = RST_PULSE;
                end
                OP_SETCFG: begin
                    w_mnhrpt = cmd.cmd_arg[0];
                    w_ovnhrp = cmd.cmd_arg[1];
                end
                default: w_err = 1'b1;
            endcase
        end else begin
            case (r_state)
                HALTING: if (w_rise) begin
                    w_state  = IDLE_HALT;
                    w_halted = 1'b1;
                    w_done   = 1'b1;
                end else w_wait = 1'b1;
                STEP_PULSE: begin
                    w_seen = r_seen | w_rise;
                    if (r_pcnt == SP_LAST) begin
                        w_mstrtp = 1'b0;
                        w_state  = STEP_WAIT;
                        w_tmo    = '0;
                    end
                end
                STEP_WAIT: if (r_seen | w_rise) begin
                    w_steps = w_steps_dec;
                    if (w_steps_dec != 16'd0) begin
                        w_state  = STEP_PULSE;
                        w_mstrtp = 1'b1;
                        w_pcnt   = '0;
                        w_seen   = 1'b0;
                    end else begin
                        w_state = IDLE_HALT;
                        w_done  = 1'b1;
                    end
                end else w_wait = 1'b1;
                RST_PULSE: begin
                    w_seen = r_seen | MGOJAM;
                    if (r_pcnt == RP_LAST) begin
                        w_strt2 = 1'b0;
                        w_state = RST_JAM;
                        w_tmo   = '0;
                    end
                end
                RST_JAM: if (MGOJAM | r_seen) begin
                    w_state = RST_CLR;
                    w_tmo   = '0;
                end else w_wait = 1'b1;
                RST_CLR: if (!MGOJAM) begin
                    w_state = w_idle;
                    w_done  = 1'b1;
                end else w_wait = 1'b1;
                default: ;
            endcase
            // Only reached when no event was seen this cycle, so an event always beats the timeout.
            if (w_wait && r_tmo == TMO_LAST) begin
                w_state  = w_idle;
                w_mstrtp = 1'b0;
                w_strt2  = 1'b0;
                w_err    = 1'b1;
                w_done   = 1'b1;
            end
        end
    end

    always_ff @(posedge SYS_CLK) begin
        if (SYS_RST) begin
            r_state  <= IDLE_RUN;
            r_mt12   <= 1'b0;
            r_mstp   <= 1'b0;
            r_mstrtp <= 1'b0;
            r_strt2  <= 1'b0;
            r_mnhrpt <= 1'b0;
            r_ovnhrp <= 1'b0;
            r_halted <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_ready  <= 1'b1;
            r_seen   <= 1'b0;
            r_steps  <= '0;
            r_pcnt   <= '0;
            r_tmo    <= '0;
        end else begin
            r_state  <= w_state;
            r_mt12   <= MT12;
            r_mstp   <= w_mstp;
            r_mstrtp <= w_mstrtp;
            r_strt2  <= w_strt2;
            r_mnhrpt <= w_mnhrpt;
            r_ovnhrp <= w_ovnhrp;
            r_halted <= w_halted;
            r_done   <= w_done;
            r_err    <= w_err;
            r_ready  <= (w_state == IDLE_RUN) || (w_state == IDLE_HALT);
            r_seen   <= w_seen;
            r_steps  <= w_steps;
            r_pcnt   <= w_pcnt;
            r_tmo    <= w_tmo;
        end
    end

    assign MSTP           = r_mstp;
    assign MSTRTP         = r_mstrtp;
    assign STRT2          = r_strt2;
    assign MNHRPT         = r_mnhrpt;
    assign OVNHRP         = r_ovnhrp;
    assign cmd.cmd_ready  = r_ready;
    assign cmd.halted     = r_halted;
    assign cmd.done       = r_done;
    assign cmd.err        = r_err;
    assign cmd.steps_left = r_steps;
endmodule

// File: tb/tb_agc_monitor_ctrl.sv
// tb_agc_monitor_ctrl: directed table plus hand-written multi-cycle sequences for agc_monitor_ctrl.
module tb_agc_monitor_ctrl;
    localparam logic [2:0] NOP = 3'd0, HALT = 3'd1, RUN = 3'd2, STEP = 3'd3, RESTART = 3'd4, SETCFG = 3'd5;

    typedef struct {
        logic [2:0]  op;
        logic [15:0] arg;
        logic        err;
        logic        mnhrpt;
        logic        ovnhrp;
        logic        mstp;
    } vec_t;

    logic clk = 1'b0, rst = 1'b1, mt12 = 1'b0, mgojam = 1'b0;
    logic mstp, mstrtp, strt2, mnhrpt, ovnhrp;
    int   n_chk = 0, n_err = 0;
    vec_t tbl [9];

    agc_monitor_ctrl_if bus();

    agc_monitor_ctrl #(.TIMEOUT_CYC(1000)) dut (
        .SYS_CLK(clk), .SYS_RST(rst), .cmd(bus), .MT12(mt12), .MGOJAM(mgojam),
        .MSTP(mstp), .MSTRTP(mstrtp), .STRT2(strt2), .MNHRPT(mnhrpt), .OVNHRP(ovnhrp)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [15:0] arg);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_arg   = arg;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int hi, n_done, done_at;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 3'd0;
        bus.cmd_arg   = 16'd0;
        tbl[0] = '{SETCFG, 16'd3, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[1] = '{NOP,    16'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{3'd6,   16'd0, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{NOP,    16'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{STEP,   16'd5, 1'b1, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{RUN,    16'd0, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[6] = '{SETCFG, 16'd2, 1'b0, 1'b0, 1'b1, 1'b0};
        tbl[7] = '{3'd7,   16'd0, 1'b1, 1'b0, 1'b1, 1'b0};
        tbl[8] = '{SETCFG, 16'd0, 1'b0, 1'b0, 1'b0, 1'b0};

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_mstp", mstp, 0);
        chk("rst_mstrtp", mstrtp, 0);
        chk("rst_strt2", strt2, 0);
        chk("rst_ready", bus.cmd_ready, 1);
        chk("rst_err", bus.err, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_steps", bus.steps_left, 0);

        // Single-cycle commands while running.
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].op, tbl[i].arg);
            chk($sformatf("vec%0d_done", i), bus.done, 1);
            chk($sformatf("vec%0d_ready", i), bus.cmd_ready, 1);
            chk($sformatf("vec%0d_err", i), bus.err, tbl[i].err);
            chk($sformatf("vec%0d_mnhrpt", i), mnhrpt, tbl[i].mnhrpt);
            chk($sformatf("vec%0d_ovnhrp", i), ovnhrp, tbl[i].ovnhrp);
            chk($sformatf("vec%0d_mstp", i), mstp, tbl[i].mstp);
            chk($sformatf("vec%0d_mstrtp", i), mstrtp, 0);
            tick();
            chk($sformatf("vec%0d_done_fall", i), bus.done, 0);
        end

        // HALT from run, MT12 rises about 40 cycles later.
        issue(HALT, 16'd0);
        chk("halt_mstp", mstp, 1);
        chk("halt_ready", bus.cmd_ready, 0);
        chk("halt_done", bus.done, 0);
        repeat (38) tick();
        chk("halt_wait_halted", bus.halted, 0);
        chk("halt_wait_ready", bus.cmd_ready, 0);
        mt12 = 1'b1;
        tick();
        chk("halt_halted", bus.halted, 1);
        chk("halt_done_rise", bus.done, 1);
        chk("halt_ready_back", bus.cmd_ready, 1);
        mt12 = 1'b0;
        tick();
        chk("halt_done_fall", bus.done, 0);
        issue(HALT, 16'd0);
        chk("halt2_done", bus.done, 1);
        chk("halt2_ready", bus.cmd_ready, 1);

        // STEP 3 while halted, MT12 rising 100 cycles after each pulse start.
        tick();
        issue(STEP, 16'd3);
        n_done = 0;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("step%0d_left", k), bus.steps_left, 32'(3 - k));
            chk($sformatf("step%0d_mstrtp", k), mstrtp, 1);
            hi = 1;
            for (int c = 1; c < 100; c++) begin
                tick();
                hi += int'(mstrtp);
                n_done += int'(bus.done);
            end
            mt12 = 1'b1;
            tick();
            n_done += int'(bus.done);
            mt12 = 1'b0;
            chk($sformatf("step%0d_width", k), hi, 64);
        end
        chk("step_left_end", bus.steps_left, 0);
        chk("step_done_cnt", n_done, 1);
        chk("step_ready", bus.cmd_ready, 1);
        chk("step_halted", bus.halted, 1);
        chk("step_mstp", mstp, 1);
        chk("step_mstrtp_end", mstrtp, 0);

        // RESTART while halted: MGOJAM high 20 cycles after STRT2 rises, low 300 later.
        tick();
        issue(RESTART, 16'd0);
        hi = 1;
        n_done = 0;
        done_at = -1;
        for (int c = 1; c <= 400; c++) begin
            mgojam = (c >= 20 && c < 320);
            tick();
            hi += int'(strt2);
            if (bus.done) begin
                n_done++;
                done_at = c;
            end
        end
        mgojam = 1'b0;
        chk("rst2_width", hi, 256);
        chk("rst2_done_at", done_at, 320);
        chk("rst2_done_cnt", n_done, 1);
        chk("rst2_mstp", mstp, 1);
        chk("rst2_halted", bus.halted, 1);
        chk("rst2_ready", bus.cmd_ready, 1);

        // STEP 2 with MT12 held low: pulse ends at edge 64, timeout 1000 cycles later.
        issue(STEP, 16'd2);
        done_at = -1;
        for (int c = 1; c <= 1200; c++) begin
            tick();
            if (bus.done && done_at < 0) done_at = c;
        end
        chk("sto_done_at", done_at, 1064);
        chk("sto_err", bus.err, 1);
        chk("sto_mstrtp", mstrtp, 0);
        chk("sto_left", bus.steps_left, 2);
        chk("sto_mstp", mstp, 1);
        chk("sto_ready", bus.cmd_ready, 1);

        // RUN clears the sticky error on accept; then HALT times out with MT12 low.
        issue(RUN, 16'd0);
        chk("run_err_clr", bus.err, 0);
        chk("run_mstp", mstp, 0);
        issue(HALT, 16'd0);
        done_at = -1;
        for (int c = 1; c <= 1100; c++) begin
            tick();
            if (bus.done && done_at < 0) done_at = c;
        end
        chk("hto_done_at", done_at, 1000);
        chk("hto_err", bus.err, 1);
        chk("hto_mstp", mstp, 1);
        chk("hto_halted", bus.halted, 0);
        chk("hto_ready", bus.cmd_ready, 1);

        // MT12 rise on the very cycle the HALT timeout expires: the event wins.
        issue(RUN, 16'd0);
        issue(HALT, 16'd0);
        done_at = -1;
        for (int c = 1; c <= 1000; c++) begin
            mt12 = (c == 1000);
            tick();
            if (bus.done && done_at < 0) done_at = c;
        end
        mt12 = 1'b0;
        chk("race_done_at", done_at, 1000);
        chk("race_err", bus.err, 0);
        chk("race_halted", bus.halted, 1);

        // SYS_RST in the middle of a STEP.
        tick();
        issue(SETCFG, 16'd3);
        issue(STEP, 16'd4);
        repeat (10) tick();
        chk("mid_mstrtp", mstrtp, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_mstp", mstp, 0);
        chk("mid_rst_mstrtp", mstrtp, 0);
        chk("mid_rst_strt2", strt2, 0);
        chk("mid_rst_mnhrpt", mnhrpt, 0);
        chk("mid_rst_ovnhrp", ovnhrp, 0);
        chk("mid_rst_halted", bus.halted, 0);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_err", bus.err, 0);
        chk("mid_rst_left", bus.steps_left, 0);
        chk("mid_rst_ready", bus.cmd_ready, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/agc_monitor_ctrl.md
# agc_monitor_ctrl

Host-facing sequencer for the AGC monitor-control inputs on the DE0-Nano build. It replaces the static tie-offs of MSTP, MSTRTP, STRT2, MNHRPT and OVNHRP with a command-driven state machine. The supported commands are halt, run, single/multi-step and restart, with completion detected from the AGC's MT12 timepulse and MGOJAM. It sits beside fpga_agc in the board top, clocked by SYS_CLK, the 51.2 MHz PLL output that also clocks the AGC state, so all AGC outputs arrive synchronous.

## Interface
- STRT_PULSE_CYC, 64: MSTRTP high time in SYS_CLK cycles (≥1).
- RESTART_PULSE_CYC, 256: STRT2 high time in SYS_CLK cycles (≥1).
- TIMEOUT_CYC, 65535: maximum wait for an AGC event per wait phase (≥1).
- SYS_CLK  in  1  system clock, 51.2 MHz.
- SYS_RST  in  1  reset, synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  controller idle and able to accept.
- cmd_op  in  3  0 NOP, 1 HALT, 2 RUN, 3 STEP, 4 RESTART, 5 SETCFG, 6–7 illegal.
- cmd_arg  in  16  STEP: step count; SETCFG: bit0→MNHRPT, bit1→OVNHRP.
- MT12  in  1  AGC timepulse 12.
- MGOJAM  in  1  AGC GOJAM monitor.
- MSTP  out  1  monitor stop to AGC.
- MSTRTP  out  1  monitor start pulse to AGC.
- STRT2  out  1  restart request to AGC.
- MNHRPT  out  1  interrupt inhibit to AGC.
- OVNHRP  out  1  overflow interrupt inhibit to AGC.
- halted  out  1  MSTP asserted and halt confirmed.
- done  out  1  one-cycle pulse when a command completes.
- err  out  1  sticky error; cleared when the next command is accepted.
- steps_left  out  16  remaining steps of the current STEP.

## Operation
- States:
  - IDLE_RUN, IDLE_HALT.
  - HALTING.
  - STEP_PULSE, STEP_WAIT.
  - RST_PULSE, RST_JAM, RST_CLR.
- cmd_ready is 1 only in IDLE_RUN and IDLE_HALT. A command is accepted on cmd_valid&cmd_ready.
- mt12_rise = MT12 & ~MT12 registered from the previous cycle.
- NOP: done only.
- SETCFG: load MNHRPT and OVNHRP from cmd_arg; done.
- HALT:
  - From IDLE_HALT: done only.
  - From IDLE_RUN: MSTP←1 and enter HALTING. On mt12_rise, enter IDLE_HALT with halted←1 and done.
- RUN: MSTP←0, halted←0, enter IDLE_RUN, done. Valid from either idle state.
- STEP:
  - Legal only in IDLE_HALT. In IDLE_RUN it is rejected: err←1, done, state unchanged.
  - arg=0: done only.
  - Otherwise steps_left←arg, then enter STEP_PULSE. MSTRTP is high for STRT_PULSE_CYC cycles. An edge-seen flag is armed from the first MSTRTP cycle.
  - After the pulse, enter STEP_WAIT until the flag is set or mt12_rise occurs. Then decrement steps_left.
  - If steps_left is now nonzero, issue the next STEP_PULSE. Otherwise return to IDLE_HALT with done.
  - MSTP stays 1 throughout.
- RESTART:
  - Legal from either idle state. In RST_PULSE, STRT2 is high for RESTART_PULSE_CYC cycles; a jam-seen flag is armed from the first STRT2 cycle.
  - RST_JAM waits for MGOJAM=1, or the flag. RST_CLR waits for MGOJAM=0.
  - Then return to the idle state matching MSTP, with done. MSTP and halted are unchanged.
- Illegal op: err←1, done, no other change.
- Timeout:
  - A counter clears on entry to HALTING, STEP_WAIT, RST_JAM and RST_CLR.
  - When it reaches TIMEOUT_CYC: err←1 and done. MSTRTP and STRT2 go to 0, steps_left is held.
  - Return to IDLE_HALT if MSTP=1, else IDLE_RUN. A timeout in HALTING leaves MSTP=1 and halted=0.

## Timing
- All outputs are registered.
- Reset values: MSTP=0, MSTRTP=0, STRT2=0, MNHRPT=0, OVNHRP=0, halted=0, done=0, err=0, steps_left=0, cmd_ready=1, state IDLE_RUN.
- SYS_RST mid-operation aborts at the next edge. All outputs take reset values and pending steps are discarded.
- Accept at edge t: the first effect (MSTP, MSTRTP, STRT2 or done) is visible after edge t+1. cmd_ready is 0 from t+1 for multi-cycle commands.
- Single-cycle commands (NOP, SETCFG, RUN, HALT when already halted, STEP 0, illegal op): done after t+1, cmd_ready stays 1.
- MSTRTP is contiguous for exactly STRT_PULSE_CYC cycles per step. There is a minimum of 1 low cycle between step pulses.
- done asserts the cycle after the completing event is sampled. cmd_ready returns in the same cycle as done.
- An event and a timeout expiring in the same cycle: the event wins and no error is raised.
- err rises with done and holds until the next accept edge.

## Test plan
- Reset → MSTP=0, MSTRTP=0, STRT2=0, cmd_ready=1, err=0. Then SETCFG arg=3 → MNHRPT=1, OVNHRP=1, done 1 cycle later.
- HALT from run, MT12 rising 40 cycles later → MSTP=1 next cycle, halted=1 with done on the cycle after the rise.
- STEP arg=3 while halted, MT12 rising 100 cycles after each pulse start → three 64-cycle MSTRTP pulses. steps_left goes 3→2→1→0, one done, ends in IDLE_HALT.
- STEP arg=5 while running → err=1, done, no MSTRTP. Then RUN → err cleared on accept.
- RESTART with MGOJAM high 20 cycles after STRT2 rises, low 300 cycles later → STRT2 high 256 cycles, done after MGOJAM falls, MSTP unchanged.
- STEP arg=2 with MT12 held 0 and TIMEOUT_CYC=1000 → err=1 and done at the timeout, MSTRTP=0, steps_left=2. SYS_RST mid-STEP → reset values next cycle.
